exe_stage: RTL and testbench

//  Execute stage of the 5-stage ARM pipeline. Consumes the ID/EXE register outputs and

---
 rtl/arm_pkg.sv | 48 ++++
 rtl/exe_stage_if.sv | 38 +++
 rtl/exe_stage_val2_gen.sv | 42 ++++
 rtl/exe_stage.sv | 105 ++++++++++
 tb/tb_exe_stage.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM execute stage: ALU op codes, shift types,
// NZCV bit positions, forward-select codes and the forwarding mux helper.
package arm_pkg;

   localparam int DW = 32;

   // ALU commands
   localparam logic [3:0] CMD_MOV = 4'b0001;
   localparam logic [3:0] CMD_MVN = 4'b1001;
   localparam logic [3:0] CMD_ADD = 4'b0010;
   localparam logic [3:0] CMD_ADC = 4'b0011;
   localparam logic [3:0] CMD_SUB = 4'b0100;
   localparam logic [3:0] CMD_SBC = 4'b0101;
   localparam logic [3:0] CMD_AND = 4'b0110;
   localparam logic [3:0] CMD_ORR = 4'b0111;
   localparam logic [3:0] CMD_EOR = 4'b1000;

   // Shifter types (shift_operand[6:5])
   localparam logic [1:0] SH_LSL = 2'b00;
   localparam logic [1:0] SH_LSR = 2'b01;
   localparam logic [1:0] SH_ASR = 2'b10;
   localparam logic [1:0] SH_ROR = 2'b11;

   // NZCV bit positions
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Forward-select codes; 2'b11 also selects the register value
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   function automatic logic [31:0] fwd_mux(input logic [1:0]  sel,
                                           input logic [31:0] reg_val,
                                           input logic [31:0] mem_val,
                                           input logic [31:0] wb_val);
      logic [31:0] r;
      case (sel)
         FWD_MEM: r = mem_val;
         FWD_WB:  r = wb_val;
         default: r = reg_val;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE inputs and EXE/MEM outputs of the execute stage, bundled.
// slave = the execute stage itself, master = whoever drives it.
interface exe_stage_if;
   logic        freeze;
   logic        imm, b, s;
   logic        mem_r_en, mem_w_en, wb_en;
   logic [3:0]  exe_cmd;
   logic [3:0]  dest;
   logic [3:0]  status_reg;
   logic [11:0] shift_operand;
   logic [23:0] signed_imm_24;
   logic [31:0] pc, val_rn, val_rm;
   logic [1:0]  sel_src1, sel_src2;
   logic [31:0] fwd_mem_val, fwd_wb_val;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic [3:0]  status;
   logic [31:0] alu_res_q;
   logic [31:0] val_rm_q;
   logic [3:0]  dest_q;
   logic        wb_en_q, mem_r_en_q, mem_w_en_q;

   modport slave (
      input  freeze, imm, b, s, mem_r_en, mem_w_en, wb_en, exe_cmd, dest,
             status_reg, shift_operand, signed_imm_24, pc, val_rn, val_rm,
             sel_src1, sel_src2, fwd_mem_val, fwd_wb_val,
      output branch_taken, branch_addr, status, alu_res_q, val_rm_q, dest_q,
             wb_en_q, mem_r_en_q, mem_w_en_q
   );

   modport master (
      output freeze, imm, b, s, mem_r_en, mem_w_en, wb_en, exe_cmd, dest,
             status_reg, shift_operand, signed_imm_24, pc, val_rn, val_rm,
             sel_src1, sel_src2, fwd_mem_val, fwd_wb_val,
      input  branch_taken, branch_addr, status, alu_res_q, val_rm_q, dest_q,
             wb_en_q, mem_r_en_q, mem_w_en_q
   );
endinterface

// File: rtl/exe_stage_val2_gen.sv
// Second-operand generator: rotated 8-bit immediate, raw 12-bit offset for
// loads/stores, or the forwarded Rm shifted by an immediate amount.
module val2_gen
   import arm_pkg::*;
(
   input  logic        imm,
   input  logic        mem_en,
   input  logic [11:0] shift_operand,
   input  logic [31:0] rm,
   output logic [31:0] val2
);

   logic [63:0] rot_wide;
   logic [4:0]  rot_amt;
   logic [4:0]  shamt;

   assign rot_amt = {shift_operand[11:8], 1'b0};
   assign shamt   = shift_operand[11:7];

   // Select and shift the second operand; rotates use a doubled word so a zero amount is identity
   always_comb begin
      val2     = rm;
      rot_wide = '0;
      if (imm) begin
         rot_wide = {24'b0, shift_operand[7:0], 24'b0, shift_operand[7:0]} >> rot_amt;
         val2     = rot_wide[31:0];
      end else if (mem_en) begin
         val2 = {20'b0, shift_operand};
      end else begin
         case (shift_operand[6:5])
            SH_LSL:  val2 = rm << shamt;
            SH_LSR:  val2 = rm >> shamt;
            SH_ASR:  val2 = $signed(rm) >>> shamt;
            default: begin
               rot_wide = {rm, rm} >> shamt;
               val2     = rot_wide[31:0];
            end
         endcase
      end
   end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: operand forwarding, ALU with NZCV generation, the
// architectural status register, branch target and the EXE/MEM register.
module exe_stage
   import arm_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic      clk,
   input  logic      rst,
   exe_stage_if.slave bus
);

   logic [DW-1:0] op_a, rm_fwd, val2, alu_res;
   logic [DW:0]   wide;
   logic          c_flag, v_flag, flags_valid;
   logic          carry_in;
   logic [3:0]    status_r;
   logic [DW-1:0] alu_res_r, val_rm_r;
   logic [3:0]    dest_r;
   logic          wb_en_r, mem_r_en_r, mem_w_en_r;
   logic          unused_status_nz;

   assign unused_status_nz = ^bus.status_reg[FLAG_N:FLAG_Z];
   assign carry_in = bus.status_reg[FLAG_C];
   assign op_a     = fwd_mux(bus.sel_src1, bus.val_rn, bus.fwd_mem_val, bus.fwd_wb_val);
   assign rm_fwd   = fwd_mux(bus.sel_src2, bus.val_rm, bus.fwd_mem_val, bus.fwd_wb_val);

   val2_gen u_val2 (
      .imm           (bus.imm),
      .mem_en        (bus.mem_r_en | bus.mem_w_en),
      .shift_operand (bus.shift_operand),
      .rm            (rm_fwd),
      .val2          (val2)
   );

   // ALU: 33-bit add/subtract for carry; logic ops pass C/V through from decode
   always_comb begin
      alu_res     = '0;
      wide        = '0;
      c_flag      = bus.status_reg[FLAG_C];
      v_flag      = bus.status_reg[FLAG_V];
      flags_valid = 1'b1;
      case (bus.exe_cmd)
         CMD_MOV: alu_res = val2;
         CMD_MVN: alu_res = ~val2;
         CMD_AND: alu_res = op_a & val2;
         CMD_ORR: alu_res = op_a | val2;
         CMD_EOR: alu_res = op_a ^ val2;
         CMD_ADD, CMD_ADC: begin
            wide    = {1'b0, op_a} + {1'b0, val2}
                    + {{DW{1'b0}}, (bus.exe_cmd == CMD_ADC) & carry_in};
            alu_res = wide[DW-1:0];
            c_flag  = wide[DW];
            v_flag  = (op_a[DW-1] == val2[DW-1]) && (alu_res[DW-1] != op_a[DW-1]);
         end
         CMD_SUB, CMD_SBC: begin
            wide    = {1'b0, op_a} - {1'b0, val2}
                    - {{DW{1'b0}}, (bus.exe_cmd == CMD_SBC) & ~carry_in};
            alu_res = wide[DW-1:0];
            c_flag  = ~wide[DW];
            v_flag  = (op_a[DW-1] != val2[DW-1]) && (alu_res[DW-1] != op_a[DW-1]);
         end
         default: flags_valid = 1'b0;
      endcase
   end

   // Status register: loads NZCV for flag-setting ops unless the pipe is frozen
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_r <= '0;
      end else if (bus.s && !bus.freeze && flags_valid) begin
         status_r <= {alu_res[DW-1], (alu_res == '0), c_flag, v_flag};
      end
   end

   // EXE/MEM register: captures results every unfrozen cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_res_r  <= '0;
         val_rm_r   <= '0;
         dest_r     <= '0;
         wb_en_r    <= 1'b0;
         mem_r_en_r <= 1'b0;
         mem_w_en_r <= 1'b0;
      end else if (!bus.freeze) begin
         alu_res_r  <= alu_res;
         val_rm_r   <= rm_fwd;
         dest_r     <= bus.dest;
         wb_en_r    <= bus.wb_en;
         mem_r_en_r <= bus.mem_r_en;
         mem_w_en_r <= bus.mem_w_en;
      end
   end

   assign bus.branch_taken = bus.b;
   assign bus.branch_addr  = bus.pc + {{6{bus.signed_imm_24[23]}}, bus.signed_imm_24, 2'b00};
   assign bus.status       = status_r;
   assign bus.alu_res_q    = alu_res_r;
   assign bus.val_rm_q     = val_rm_r;
   assign bus.dest_q       = dest_r;
   assign bus.wb_en_q      = wb_en_r;
   assign bus.mem_r_en_q   = mem_r_en_r;
   assign bus.mem_w_en_q   = mem_w_en_r;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: a reference model predicts each captured
// EXE/MEM word and NZCV, monitors compare against the queued predictions.
module tb_exe_stage;

   logic clk;
   logic rst;
   exe_stage_if bus ();

   exe_stage dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        imm, b, s, mem_r, mem_w, wb;
      logic [3:0]  cmd, dest, sr;
      logic [11:0] so;
      logic [23:0] off;
      logic [31:0] pc, rn, rm, fm, fw;
      logic [1:0]  s1, s2;
   } op_t;

   typedef struct {
      logic [31:0] res, rm;
      logic [3:0]  dest, status;
      logic [2:0]  ctl;
   } exp_t;

   typedef struct {
      logic        taken;
      logic [31:0] addr;
   } br_t;

   exp_t sq[$];
   br_t  bq[$];
   exp_t last;
   logic [3:0] model_status;
   int checks = 0;
   int errors = 0;
   int txn = 0;
   logic [3:0] valid_cmds [9] = '{4'h1, 4'h9, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- reference model ----------------
   function automatic logic [31:0] m_sel(input logic [1:0] sel, input logic [31:0] r,
                                         input logic [31:0] m, input logic [31:0] w);
      if (sel == 2'd1) return m;
      if (sel == 2'd2) return w;
      return r;
   endfunction

   function automatic logic [31:0] m_ror(input logic [31:0] x, input int n);
      logic [31:0] r = x;
      for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
      return r;
   endfunction

   function automatic logic [31:0] m_val2(input op_t op, input logic [31:0] rmv);
      int n;
      longint sx;
      if (op.imm) return m_ror({24'b0, op.so[7:0]}, 2 * int'(op.so[11:8]));
      if (op.mem_r || op.mem_w) return {20'b0, op.so};
      n = int'(op.so[11:7]);
      case (op.so[6:5])
         2'd0: return rmv << n;
         2'd1: return rmv >> n;
         2'd2: begin
            sx = $signed(rmv);
            sx = sx >>> n;
            return sx[31:0];
         end
         default: return m_ror(rmv, n);
      endcase
   endfunction

   function automatic void m_alu(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] v2,
                                 input logic [3:0] sr, output logic [31:0] res,
                                 output logic c, output logic v, output logic ok);
      longint unsigned ua = a;
      longint unsigned ub = v2;
      longint sa = $signed(a);
      longint sb = $signed(v2);
      longint unsigned u;
      longint sres;
      longint unsigned k;
      ok = 1'b1; c = sr[1]; v = sr[0]; res = '0;
      case (cmd)
         4'h1: res = v2;
         4'h9: res = ~v2;
         4'h6: res = a & v2;
         4'h7: res = a | v2;
         4'h8: res = a ^ v2;
         4'h2, 4'h3: begin
            k = (cmd == 4'h3) ? longint'(sr[1]) : 0;
            u = ua + ub + k;
            res = u[31:0];
            c = (u > 64'hFFFF_FFFF);
            sres = sa + sb + longint'(k);
            v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
         end
         4'h4, 4'h5: begin
            k = (cmd == 4'h5) ? longint'(!sr[1]) : 0;
            u = ua - ub - k;
            res = u[31:0];
            c = (ua >= ub + k);
            sres = sa - sb - longint'(k);
            v = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
         end
         default: ok = 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] m_branch(input logic [31:0] pc, input logic [23:0] off);
      longint o = longint'(off);
      longint t;
      if (o >= 64'sd8388608) o = o - 64'sd16777216;
      t = longint'(pc) + 4 * o;
      return t[31:0];
   endfunction

   // ---------------- driver ----------------
   task automatic drive(input op_t op, input logic fz);
      logic [31:0] a, rmv, v2, res;
      logic c, v, ok;
      exp_t e;
      br_t  be;
      @(negedge clk);
      bus.freeze = fz;
      bus.imm = op.imm; bus.b = op.b; bus.s = op.s;
      bus.mem_r_en = op.mem_r; bus.mem_w_en = op.mem_w; bus.wb_en = op.wb;
      bus.exe_cmd = op.cmd; bus.dest = op.dest; bus.status_reg = op.sr;
      bus.shift_operand = op.so; bus.signed_imm_24 = op.off;
      bus.pc = op.pc; bus.val_rn = op.rn; bus.val_rm = op.rm;
      bus.sel_src1 = op.s1; bus.sel_src2 = op.s2;
      bus.fwd_mem_val = op.fm; bus.fwd_wb_val = op.fw;
      be.taken = op.b;
      be.addr  = m_branch(op.pc, op.off);
      bq.push_back(be);
      if (!fz) begin
         a   = m_sel(op.s1, op.rn, op.fm, op.fw);
         rmv = m_sel(op.s2, op.rm, op.fm, op.fw);
         v2  = m_val2(op, rmv);
         m_alu(op.cmd, a, v2, op.sr, res, c, v, ok);
         if (op.s && ok) model_status = {res[31], (res == 32'd0), c, v};
         e.res = res; e.rm = rmv; e.dest = op.dest; e.status = model_status;
         e.ctl = {op.wb, op.mem_r, op.mem_w};
         sq.push_back(e);
      end
   endtask

   function automatic op_t base_op();
      op_t op;
      op.imm = 0; op.b = 0; op.s = 0; op.mem_r = 0; op.mem_w = 0; op.wb = 1;
      op.cmd = 4'h2; op.dest = 4'h3; op.sr = 4'h0; op.so = '0; op.off = '0;
      op.pc = '0; op.rn = '0; op.rm = '0; op.fm = '0; op.fw = '0;
      op.s1 = 2'd0; op.s2 = 2'd0;
      return op;
   endfunction

   function automatic op_t rand_op();
      op_t op;
      int idx = $urandom_range(0, 11);
      op.cmd = (idx < 9) ? valid_cmds[idx] : 4'($urandom_range(10, 15));
      op.s = (idx < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
      op.imm = 1'($urandom_range(0, 1));
      op.mem_r = ($urandom_range(0, 5) == 0);
      op.mem_w = !op.mem_r && ($urandom_range(0, 5) == 0);
      op.wb = 1'($urandom_range(0, 1));
      op.b = ($urandom_range(0, 7) == 0);
      op.dest = 4'($urandom); op.sr = 4'($urandom);
      op.so = 12'($urandom); op.off = 24'($urandom);
      op.pc = $urandom; op.rn = $urandom; op.rm = $urandom;
      op.fm = ($urandom_range(0, 3) == 0) ? op.rn : $urandom;
      op.fw = $urandom;
      op.s1 = 2'($urandom); op.s2 = 2'($urandom);
      return op;
   endfunction

   // ---------------- monitors ----------------
   // EXE/MEM + status: pop a prediction on each unfrozen edge, otherwise expect a hold
   always @(posedge clk) begin
      logic fz;
      exp_t e;
      if (!rst) begin
         fz = bus.freeze;
         #1;
         if (!fz) begin
            if (sq.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
            end else begin
               e = sq.pop_front();
               last = e;
               txn++;
               $display("txn %0d res=%h rm=%h dest=%h ctl=%b nzcv=%b", txn,
                        bus.alu_res_q, bus.val_rm_q, bus.dest_q,
                        {bus.wb_en_q, bus.mem_r_en_q, bus.mem_w_en_q}, bus.status);
            end
         end
         chk("alu_res_q", bus.alu_res_q, last.res);
         chk("val_rm_q", bus.val_rm_q, last.rm);
         chk("dest_q", {28'd0, bus.dest_q}, {28'd0, last.dest});
         chk("ctl_q", {29'd0, bus.wb_en_q, bus.mem_r_en_q, bus.mem_w_en_q}, {29'd0, last.ctl});
         chk("status", {28'd0, bus.status}, {28'd0, last.status});
      end
   end

   // Branch outputs are combinational: check them shortly after each drive
   always @(negedge clk) begin
      br_t be;
      #2;
      if (bq.size() > 0) begin
         be = bq.pop_front();
         chk("branch_taken", {31'd0, bus.branch_taken}, {31'd0, be.taken});
         chk("branch_addr", bus.branch_addr, be.addr);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      op_t op, cur;
      last = '{res: '0, rm: '0, dest: '0, status: '0, ctl: '0};
      model_status = 4'h0;
      cur = base_op();
      rst = 1'b1;
      bus.freeze = 1'b1;
      bus.imm = 0; bus.b = 0; bus.s = 0; bus.mem_r_en = 0; bus.mem_w_en = 0; bus.wb_en = 0;
      bus.exe_cmd = 0; bus.dest = 0; bus.status_reg = 0; bus.shift_operand = 0;
      bus.signed_imm_24 = 0; bus.pc = 0; bus.val_rn = 0; bus.val_rm = 0;
      bus.sel_src1 = 0; bus.sel_src2 = 0; bus.fwd_mem_val = 0; bus.fwd_wb_val = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_alu_res_q", bus.alu_res_q, 32'd0);
      chk("reset_status", {28'd0, bus.status}, 32'd0);

      // ADD overflow
      op = base_op(); op.rn = 32'h7FFF_FFFF; op.imm = 1; op.so = 12'h001; op.cmd = 4'h2; op.s = 1;
      drive(op, 0);
      @(posedge clk); #2;
      chk("add_ovf_res", bus.alu_res_q, 32'h8000_0000);
      chk("add_ovf_nzcv", {28'd0, bus.status}, 32'h9);

      // SUB with rotated immediate
      op = base_op(); op.rn = 32'd5; op.imm = 1; op.so = 12'h105; op.cmd = 4'h4; op.s = 1;
      drive(op, 0);
      @(posedge clk); #2;
      chk("sub_ror_res", bus.alu_res_q, 32'hC000_0004);
      chk("sub_ror_nc", {30'd0, bus.status[3], bus.status[1]}, 32'h2);

      // SUB to zero
      op.so = 12'h005;
      drive(op, 0);
      @(posedge clk); #2;
      chk("sub_zero_res", bus.alu_res_q, 32'd0);
      chk("sub_zero_zc", {30'd0, bus.status[2], bus.status[1]}, 32'h3);

      // Forwarding from MEM then WB
      op = base_op(); op.rn = 32'd1; op.fm = 32'd10; op.fw = 32'd20; op.imm = 1; op.so = 12'h003;
      op.s1 = 2'b01;
      drive(op, 0);
      @(posedge clk); #2;
      chk("fwd_mem", bus.alu_res_q, 32'd13);
      op.s1 = 2'b10;
      drive(op, 0);
      @(posedge clk); #2;
      chk("fwd_wb", bus.alu_res_q, 32'd23);

      // Freeze for three cycles with a flag-setting op, then release
      op = base_op(); op.rn = 32'hFFFF_FFFF; op.imm = 1; op.so = 12'h001; op.s = 1; op.dest = 4'hA;
      repeat (3) drive(op, 1);
      drive(op, 0);

      // Branch
      op = base_op(); op.pc = 32'h100; op.off = 24'hFFFFFE; op.b = 1; op.wb = 0;
      drive(op, 0);
      #2;
      chk("br_taken", {31'd0, bus.branch_taken}, 32'd1);
      chk("br_addr", bus.branch_addr, 32'hF8);
      @(posedge clk); #2;
      chk("br_wb_en_q", {31'd0, bus.wb_en_q}, 32'd0);

      // Randomized stream with random freezes
      for (int i = 0; i < 250; i++) begin
         if (i > 0 && $urandom_range(0, 4) == 0) begin
            drive(cur, 1);
         end else begin
            cur = rand_op();
            drive(cur, 0);
         end
      end

      // Reset in the middle of an in-flight op
      op = base_op(); op.rn = 32'h1234; op.imm = 1; op.so = 12'h0FF; op.s = 1; op.cmd = 4'h2;
      drive(op, 0);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_alu_res_q", bus.alu_res_q, 32'd0);
      chk("midrst_val_rm_q", bus.val_rm_q, 32'd0);
      chk("midrst_status", {28'd0, bus.status}, 32'd0);
      sq.delete();
      last = '{res: '0, rm: '0, dest: '0, status: '0, ctl: '0};
      model_status = 4'h0;
      @(negedge clk);
      bus.freeze = 1'b1;
      rst = 1'b0;

      for (int i = 0; i < 40; i++) begin
         cur = rand_op();
         drive(cur, ($urandom_range(0, 3) == 0));
      end
      drive(cur, 1);
      repeat (2) @(negedge clk);
      chk("sb_drained", sq.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
